// File: rtl/tx_pull_fifo_pkg.sv
// Shared TX pull definitions: default depth, pull-threshold decode, FDEBUG sticky bit positions.
// Optional TX_JOIN_EN doubles capacity in tx_pull_fifo; nothing here depends on it.
package tx_pull_fifo_pkg;

  localparam int DEFAULT_DEPTH = 4;

  // Base bit positions of the per-SM sticky flags in FDEBUG (add the SM index).
  localparam int FDEBUG_TXSTALL_LSB = 24;
  localparam int FDEBUG_TXOVER_LSB  = 16;

  function automatic logic [5:0] thr_decode(input logic [4:0] thresh);
    return (thresh == 5'd0) ? 6'd32 : {1'b0, thresh};
  endfunction

endpackage

// File: rtl/tx_pull_fifo_if.sv
// System-bus push side of the TX FIFO plus occupancy status.
// Level gains one extra bit when TX_JOIN_EN is defined.
interface tx_pull_fifo_if #(
  parameter int DEPTH = tx_pull_fifo_pkg::DEFAULT_DEPTH
);
  localparam int PTR_W = $clog2(DEPTH);
`ifdef TX_JOIN_EN
  localparam int LVL_W = PTR_W + 2;
`else
  localparam int LVL_W = PTR_W + 1;
`endif

  logic             push_valid;
  logic [31:0]      push_data;
  logic             push_ready;
  logic             full;
  logic             empty;
  logic [LVL_W-1:0] level;

  modport master (output push_valid, push_data, input push_ready, full, empty, level);
  modport slave  (input push_valid, push_data, output push_ready, full, empty, level);

endinterface

// File: rtl/tx_pull_fifo_mem.sv
// DEPTH x 32 storage array: registered write port, asynchronous read of the head entry.
module tx_pull_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tx_pull_fifo.sv
// TX FIFO feeding the output shift register via PULL/autopull, with stall and TXSTALL/TXOVER flags.
// TX_JOIN_EN: adds join_rx_into_tx, doubling capacity with a second storage bank borrowed from RX.
module tx_pull_fifo
  import tx_pull_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        penable,
  input  logic        restart,
  input  logic        clear,
  tx_pull_fifo_if.slave bus,
  input  logic        pull_req,
  input  logic        pull_block,
  input  logic        pull_ifempty,
  input  logic        out_req,
  input  logic        autopull_en,
  input  logic [4:0]  pull_thresh,
  input  logic [5:0]  osr_count,
  input  logic [31:0] x_value,
  output logic        osr_set,
  output logic [31:0] osr_din,
  output logic        stall,
  output logic        txstall,
  output logic        txover,
`ifdef TX_JOIN_EN
  input  logic        join_rx_into_tx,
`endif
  input  logic        txstall_clr,
  input  logic        txover_clr
);

`ifdef TX_JOIN_EN
  localparam int LVL_W = PTR_W + 2;
  localparam int PW    = PTR_W + 1;
`else
  localparam int LVL_W = PTR_W + 1;
  localparam int PW    = PTR_W;
`endif

  logic [LVL_W-1:0] cap, level_q;
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [31:0]      head;
  logic             full, empty, push_acc, pop, stall_set, enough;

  // Restart leaves FIFO state alone; the shift register's count reset drives the refill.
  wire unused_restart = restart;

`ifdef TX_JOIN_EN
  assign cap = join_rx_into_tx ? LVL_W'(2 * DEPTH) : LVL_W'(DEPTH);
`else
  assign cap = LVL_W'(DEPTH);
`endif

  assign full     = (level_q == cap);
  assign empty    = (level_q == '0);
  assign push_acc = bus.push_valid && !full;
  assign wr_nxt   = (LVL_W'(wr_ptr) == cap - 1'b1) ? '0 : wr_ptr + 1'b1;
  assign rd_nxt   = (LVL_W'(rd_ptr) == cap - 1'b1) ? '0 : rd_ptr + 1'b1;

  assign bus.push_ready = !full;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.level      = level_q;

`ifdef TX_JOIN_EN
  logic [31:0] rdata0, rdata1;
  tx_pull_fifo_mem #(.DEPTH(DEPTH)) u_mem0 (
    .clk(clk), .we(push_acc && !wr_ptr[PW-1]), .waddr(wr_ptr[PTR_W-1:0]),
    .wdata(bus.push_data), .raddr(rd_ptr[PTR_W-1:0]), .rdata(rdata0));
  // Upper half of the joined address space lives in the storage borrowed from RX.
  tx_pull_fifo_mem #(.DEPTH(DEPTH)) u_mem1 (
    .clk(clk), .we(push_acc && wr_ptr[PW-1]), .waddr(wr_ptr[PTR_W-1:0]),
    .wdata(bus.push_data), .raddr(rd_ptr[PTR_W-1:0]), .rdata(rdata1));
  assign head = rd_ptr[PW-1] ? rdata1 : rdata0;
`else
  tx_pull_fifo_mem #(.DEPTH(DEPTH)) u_mem0 (
    .clk(clk), .we(push_acc), .waddr(wr_ptr), .wdata(bus.push_data),
    .raddr(rd_ptr), .rdata(head));
`endif

  assign enough = (osr_count >= thr_decode(pull_thresh));

  always_comb begin
    osr_set   = 1'b0;
    osr_din   = head;
    stall     = 1'b0;
    pop       = 1'b0;
    stall_set = 1'b0;
    if (penable) begin
      if (pull_req) begin
        if (pull_ifempty && !enough) begin
        end else if (autopull_en && !enough) begin
        end else if (!empty) begin
          osr_set = 1'b1;
          pop     = 1'b1;
        end else if (pull_block) begin
          stall     = 1'b1;
          stall_set = 1'b1;
        end else begin
          osr_set = 1'b1;
          osr_din = x_value;
        end
      end else if (autopull_en && enough) begin
        if (!empty) begin
          osr_set = 1'b1;
          pop     = 1'b1;
        end else if (out_req) begin
          stall     = 1'b1;
          stall_set = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_nxt;
      if (pop)      rd_ptr <= rd_nxt;
      case ({push_acc, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      txstall <= 1'b0;
      txover  <= 1'b0;
    end else begin
      if (txstall_clr)    txstall <= 1'b0;
      else if (stall_set) txstall <= 1'b1;
      if (txover_clr)                    txover <= 1'b0;
      else if (bus.push_valid && full)   txover <= 1'b1;
    end
  end

endmodule

// File: doc/tx_pull_fifo.md
Name: tx_pull_fifo

Overview:
Per-state-machine TX path stage directly upstream of the output shift register.
- Buffers 32-bit words written by the system bus in a small circular FIFO.
- Loads the shift register through its set/din interface, either on an explicit PULL instruction or on autopull when the shift count reaches the threshold.
- Generates the PULL/OUT stall signals and the TXSTALL/TXOVER sticky debug flags.

Parameters:
DEPTH, 4, FIFO entries, power of two ≥2.
PTR_W, $clog2(DEPTH), pointer width; level width is PTR_W+1 (PTR_W+2 with TX_JOIN_EN).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high; clock clk
penable  in  1  state-machine clock enable
restart  in  1  SM restart; FIFO contents and sticky flags unaffected
clear  in  1  flush FIFO (pointers and level to 0)
push_valid  in  1  bus write strobe
push_data  in  32  bus write data
push_ready  out  1  !full
full  out  1  level == capacity
empty  out  1  level == 0
level  out  PTR_W+1  current occupancy
pull_req  in  1  PULL instruction executing this cycle
pull_block  in  1  PULL block bit
pull_ifempty  in  1  PULL ifempty bit
out_req  in  1  OUT instruction executing this cycle
autopull_en  in  1  autopull enabled
pull_thresh  in  5  threshold; 0 encodes 32
osr_count  in  6  shift count from the shift register
x_value  in  32  scratch X; loaded on a non-blocking PULL when the FIFO is empty
osr_set  out  1  load strobe to the shift register
osr_din  out  32  load data
stall  out  1  SM must stall this cycle
txstall  out  1  sticky: a blocking pull or OUT stalled on empty
txover  out  1  sticky: push was dropped while full
txstall_clr  in  1  write-1 clear for txstall
txover_clr  in  1  write-1 clear for txover

Behaviour:
Reset and clear:
- reset: pointers=0, level=0, txstall=0, txover=0.
- clear: pointers=0, level=0; sticky flags unaffected.

Push side:
- Registered. Push is accepted when push_valid && !full, independent of penable.
- Push while full: word dropped, txover<=1.
- No fall-through: a word pushed in cycle N is visible to pull logic in N+1.
- Push and pop in the same cycle: level unchanged.

Pull logic (thr = pull_thresh==0 ? 32 : pull_thresh; osr_full_enough = osr_count >= thr):
- Combinational, evaluated only when penable. Outside penable, osr_set=0 and stall=0.
- Explicit pull (pull_req=1) takes priority; autopull is suppressed in that cycle.
  - pull_ifempty && osr_count < thr: no-op, stall=0.
  - Else if autopull_en && osr_count < thr: no-op, because autopull owns refill.
  - Else if !empty: osr_set=1, osr_din=head, pop.
  - Else if pull_block: stall=1, txstall<=1.
  - Else (non-blocking, empty): osr_set=1, osr_din=x_value, no pop.
- Autopull (pull_req=0):
  - autopull_en && osr_full_enough && !empty: osr_set=1, osr_din=head, pop. Refill happens in the background, whether or not out_req is set.
  - autopull_en && osr_full_enough && empty && out_req: stall=1, txstall<=1.
- osr_set is never asserted while stall=1.

Other rules:
- The sticky clear inputs win over a same-cycle set.
- restart has no effect on this block. The shift register's count goes to 32 on restart, so the next cycle's autopull refills naturally.
- Pointer wrap is modulo capacity. Level arithmetic is saturating-free: guarded by the full/empty checks above.

Optional Feature:
TX_JOIN_EN
- Defined: adds input join_rx_into_tx (1 bit). When it is 1, capacity = 2*DEPTH, with storage borrowed from the paired RX array through a second storage instance. full, level and the pointers use the doubled capacity. Changing join_rx_into_tx requires clear, and contents are undefined until then.
- Undefined: capacity is fixed at DEPTH, and no join port exists.

Decomposition:
Shared package/include pio_defs:
- threshold-decode function (0→32)
- default DEPTH
- sticky flag bit positions for the FDEBUG register

Sub-module tx_fifo_mem: DEPTH×32 register array with write port and asynchronous read of the head. It is instantiated twice under TX_JOIN_EN.

Test Plan:
1. Reset, push 0xA5A5A5A5 then 0x12345678 → level=2. PULL block → osr_set=1, osr_din=0xA5A5A5A5, level=1 next cycle.
2. Empty FIFO, PULL block with penable=1 for 3 cycles → stall=1 each cycle, txstall=1. Push 0xDEADBEEF → the next cycle gives osr_set with 0xDEADBEEF, stall=0.
3. Empty FIFO, PULL non-blocking, x_value=0x0000CAFE → osr_set=1, osr_din=0x0000CAFE, level stays 0, stall=0.
4. autopull_en=1, pull_thresh=0, osr_count=32, FIFO holds 0x1 → background osr_set with 0x1. With osr_count=32, FIFO empty and out_req=1 → stall=1.
5. Push 4 words (DEPTH=4) → full=1, push_ready=0. 5th push → dropped, txover=1. txover_clr → txover=0.
6. PULL ifempty with osr_count=8, thr=16, FIFO non-empty → no osr_set, no pop, stall=0. Push and pop in the same cycle with level=2 → level stays 2.
